// File: rtl/control_pkg.sv
// Shared RV32I types for the multicycle control FSM: opcodes, funct3
// encodings, ALU/CMP operations, datapath mux selects, FSM states and a
// bundle of every control output plus helpers that build it.
package control_pkg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    load_lb  = 3'b000,
    load_lh  = 3'b001,
    load_lw  = 3'b010,
    load_lbu = 3'b100,
    load_lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    store_sb = 3'b000,
    store_sh = 3'b001,
    store_sw = 3'b010
  } store_funct3_t;

  typedef enum logic [2:0] {
    arith_add  = 3'b000,
    arith_sll  = 3'b001,
    arith_slt  = 3'b010,
    arith_sltu = 3'b011,
    arith_xor  = 3'b100,
    arith_sr   = 3'b101,
    arith_or   = 3'b110,
    arith_and  = 3'b111
  } arith_funct3_t;

  typedef enum logic [1:0] {
    pcmux_pc_plus4 = 2'd0,
    pcmux_alu_out  = 2'd1,
    pcmux_alu_mod2 = 2'd2
  } pcmux_sel_t;

  typedef enum logic {
    alumux1_rs1_out = 1'b0,
    alumux1_pc_out  = 1'b1
  } alumux1_sel_t;

  typedef enum logic [2:0] {
    alumux2_i_imm   = 3'd0,
    alumux2_u_imm   = 3'd1,
    alumux2_b_imm   = 3'd2,
    alumux2_s_imm   = 3'd3,
    alumux2_j_imm   = 3'd4,
    alumux2_rs2_out = 3'd5
  } alumux2_sel_t;

  typedef enum logic [3:0] {
    regfilemux_alu_out  = 4'd0,
    regfilemux_br_en    = 4'd1,
    regfilemux_u_imm    = 4'd2,
    regfilemux_lw       = 4'd3,
    regfilemux_pc_plus4 = 4'd4,
    regfilemux_lb       = 4'd5,
    regfilemux_lbu      = 4'd6,
    regfilemux_lh       = 4'd7,
    regfilemux_lhu      = 4'd8
  } regfilemux_sel_t;

  typedef enum logic {
    marmux_pc_out  = 1'b0,
    marmux_alu_out = 1'b1
  } marmux_sel_t;

  typedef enum logic {
    cmpmux_rs2_out = 1'b0,
    cmpmux_i_imm   = 1'b1
  } cmpmux_sel_t;

  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, DECODE,
    LUI, AUIPC, IMM, REG, BR, JAL, JALR,
    CALC_ADDR, LD1, LD2, ST1, ST2
  } state_t;

  // Every control output of the FSM, so decode can be written as
  // "start from defaults, then override".
  typedef struct packed {
    logic            load_pc;
    logic            load_ir;
    logic            load_regfile;
    logic            load_mar;
    logic            load_mdr;
    logic            load_data_out;
    pcmux_sel_t      pcmux_sel;
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    regfilemux_sel_t regfilemux_sel;
    marmux_sel_t     marmux_sel;
    cmpmux_sel_t     cmpmux_sel;
    alu_ops          aluop;
    branch_funct3_t  cmpop;
    logic [3:0]      mem_byte_enable;
    logic            mem_read;
    logic            mem_write;
  } ctrl_t;

  function automatic ctrl_t set_defaults(input logic [2:0] f3);
    ctrl_t c;
    c.load_pc         = 1'b0;
    c.load_ir         = 1'b0;
    c.load_regfile    = 1'b0;
    c.load_mar        = 1'b0;
    c.load_mdr        = 1'b0;
    c.load_data_out   = 1'b0;
    c.pcmux_sel       = pcmux_pc_plus4;
    c.alumux1_sel     = alumux1_rs1_out;
    c.alumux2_sel     = alumux2_i_imm;
    c.regfilemux_sel  = regfilemux_alu_out;
    c.marmux_sel      = marmux_pc_out;
    c.cmpmux_sel      = cmpmux_rs2_out;
    c.aluop           = alu_ops'(f3);
    c.cmpop           = branch_funct3_t'(f3);
    c.mem_byte_enable = 4'b1111;
    c.mem_read        = 1'b0;
    c.mem_write       = 1'b0;
    return c;
  endfunction

  function automatic ctrl_t with_load_regfile(input ctrl_t c, input regfilemux_sel_t sel);
    ctrl_t r;
    r                = c;
    r.load_regfile   = 1'b1;
    r.regfilemux_sel = sel;
    return r;
  endfunction

  function automatic ctrl_t with_load_pc(input ctrl_t c, input pcmux_sel_t sel);
    ctrl_t r;
    r           = c;
    r.load_pc   = 1'b1;
    r.pcmux_sel = sel;
    return r;
  endfunction

  // Byte lanes for a store; sub-word stores shift by the low address bits.
  function automatic logic [3:0] store_byte_enable(input logic [2:0] f3, input logic [1:0] align);
    logic [3:0] be;
    case (store_funct3_t'(f3))
      store_sb: be = 4'b0001 << align;
      store_sh: be = 4'b0011 << align;
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/control.sv
// Multicycle RV32I control FSM. Sequences the datapath (PC, IR, MAR, MDR,
// regfile, ALU, CMP) and runs the fetch/load/store memory handshake.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   opcode, funct3, funct7    decoded IR fields
//   br_en                     CMP result
//   rs1, rs2                  IR source fields (monitor only, unused here)
//   mem_align                 MAR[1:0], selects store byte lanes
//   mem_resp                  one-cycle memory completion pulse
//   load_*                    datapath register loads
//   *mux_sel, aluop, cmpop    datapath selects and operations
//   mem_byte_enable           store byte lanes
//   mem_read, mem_write       memory requests, held until mem_resp
module control
  import control_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            br_en,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [1:0]      mem_align,
  input  logic            mem_resp,
  output logic            load_pc,
  output logic            load_ir,
  output logic            load_regfile,
  output logic            load_mar,
  output logic            load_mdr,
  output logic            load_data_out,
  output pcmux_sel_t      pcmux_sel,
  output alumux1_sel_t    alumux1_sel,
  output alumux2_sel_t    alumux2_sel,
  output regfilemux_sel_t regfilemux_sel,
  output marmux_sel_t     marmux_sel,
  output cmpmux_sel_t     cmpmux_sel,
  output alu_ops          aluop,
  output branch_funct3_t  cmpop,
  output logic [3:0]      mem_byte_enable,
  output logic            mem_read,
  output logic            mem_write
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  // Source register indices are carried for debug visibility only.
  logic unused_inputs;
  assign unused_inputs = ^{rs1, rs2, funct7[6], funct7[4:0]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH1;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctrl    = set_defaults(funct3);

    case (state_q)
      FETCH1: begin
        ctrl.load_mar   = 1'b1;
        ctrl.marmux_sel = marmux_pc_out;
        state_d         = FETCH2;
      end

      FETCH2: begin
        ctrl.mem_read = 1'b1;
        ctrl.load_mdr = 1'b1;
        if (mem_resp) state_d = FETCH3;
      end

      FETCH3: begin
        ctrl.load_ir = 1'b1;
        state_d      = DECODE;
      end

      DECODE: begin
        case (rv32i_opcode'(opcode))
          op_lui:   state_d = LUI;
          op_auipc: state_d = AUIPC;
          op_jal:   state_d = JAL;
          op_jalr:  state_d = JALR;
          op_br:    state_d = BR;
          op_load:  state_d = CALC_ADDR;
          op_store: state_d = CALC_ADDR;
          op_imm:   state_d = IMM;
          op_reg:   state_d = REG;
          default: begin
            // Unknown opcodes retire as a NOP; this is the only place the
            // PC can step past them, so it is loaded here.
            ctrl    = with_load_pc(ctrl, pcmux_pc_plus4);
            state_d = FETCH1;
          end
        endcase
      end

      LUI: begin
        ctrl    = with_load_regfile(ctrl, regfilemux_u_imm);
        ctrl    = with_load_pc(ctrl, pcmux_pc_plus4);
        state_d = FETCH1;
      end

      AUIPC: begin
        ctrl.alumux1_sel = alumux1_pc_out;
        ctrl.alumux2_sel = alumux2_u_imm;
        ctrl.aluop       = alu_add;
        ctrl             = with_load_regfile(ctrl, regfilemux_alu_out);
        ctrl             = with_load_pc(ctrl, pcmux_pc_plus4);
        state_d          = FETCH1;
      end

      IMM: begin
        case (arith_funct3_t'(funct3))
          arith_slt: begin
            ctrl.cmpmux_sel = cmpmux_i_imm;
            ctrl.cmpop      = blt;
            ctrl            = with_load_regfile(ctrl, regfilemux_br_en);
          end
          arith_sltu: begin
            ctrl.cmpmux_sel = cmpmux_i_imm;
            ctrl.cmpop      = bltu;
            ctrl            = with_load_regfile(ctrl, regfilemux_br_en);
          end
          arith_sr: begin
            ctrl.aluop = funct7[5] ? alu_sra : alu_srl;
            ctrl       = with_load_regfile(ctrl, regfilemux_alu_out);
          end
          default: ctrl = with_load_regfile(ctrl, regfilemux_alu_out);
        endcase
        ctrl    = with_load_pc(ctrl, pcmux_pc_plus4);
        state_d = FETCH1;
      end

      REG: begin
        ctrl.alumux2_sel = alumux2_rs2_out;
        case (arith_funct3_t'(funct3))
          arith_add: begin
            ctrl.aluop = funct7[5] ? alu_sub : alu_add;
            ctrl       = with_load_regfile(ctrl, regfilemux_alu_out);
          end
          arith_sr: begin
            ctrl.aluop = funct7[5] ? alu_sra : alu_srl;
            ctrl       = with_load_regfile(ctrl, regfilemux_alu_out);
          end
          arith_slt: begin
            ctrl.cmpmux_sel = cmpmux_rs2_out;
            ctrl.cmpop      = blt;
            ctrl            = with_load_regfile(ctrl, regfilemux_br_en);
          end
          arith_sltu: begin
            ctrl.cmpmux_sel = cmpmux_rs2_out;
            ctrl.cmpop      = bltu;
            ctrl            = with_load_regfile(ctrl, regfilemux_br_en);
          end
          default: ctrl = with_load_regfile(ctrl, regfilemux_alu_out);
        endcase
        ctrl    = with_load_pc(ctrl, pcmux_pc_plus4);
        state_d = FETCH1;
      end

      BR: begin
        ctrl.alumux1_sel = alumux1_pc_out;
        ctrl.alumux2_sel = alumux2_b_imm;
        ctrl.aluop       = alu_add;
        ctrl             = with_load_pc(ctrl, br_en ? pcmux_alu_out : pcmux_pc_plus4);
        state_d          = FETCH1;
      end

      // Jump funct3 bits are immediate bits for JAL, so the add is forced.
      JAL: begin
        ctrl.alumux1_sel = alumux1_pc_out;
        ctrl.alumux2_sel = alumux2_j_imm;
        ctrl.aluop       = alu_add;
        ctrl             = with_load_regfile(ctrl, regfilemux_pc_plus4);
        ctrl             = with_load_pc(ctrl, pcmux_alu_mod2);
        state_d          = FETCH1;
      end

      // Regfile and PC load on the same edge, so rd == rs1 still sees the
      // old rs1 in the target computation.
      JALR: begin
        ctrl.alumux2_sel = alumux2_i_imm;
        ctrl.aluop       = alu_add;
        ctrl             = with_load_regfile(ctrl, regfilemux_pc_plus4);
        ctrl             = with_load_pc(ctrl, pcmux_alu_mod2);
        state_d          = FETCH1;
      end

      CALC_ADDR: begin
        ctrl.marmux_sel = marmux_alu_out;
        ctrl.aluop      = alu_add;
        ctrl.load_mar   = 1'b1;
        if (rv32i_opcode'(opcode) == op_store) begin
          ctrl.alumux2_sel     = alumux2_s_imm;
          ctrl.load_data_out   = 1'b1;
          ctrl.mem_byte_enable = store_byte_enable(funct3, mem_align);
          state_d              = ST1;
        end else begin
          ctrl.alumux2_sel = alumux2_i_imm;
          state_d          = LD1;
        end
      end

      LD1: begin
        ctrl.mem_read = 1'b1;
        ctrl.load_mdr = 1'b1;
        if (mem_resp) state_d = LD2;
      end

      LD2: begin
        case (load_funct3_t'(funct3))
          load_lb:  ctrl = with_load_regfile(ctrl, regfilemux_lb);
          load_lh:  ctrl = with_load_regfile(ctrl, regfilemux_lh);
          load_lbu: ctrl = with_load_regfile(ctrl, regfilemux_lbu);
          load_lhu: ctrl = with_load_regfile(ctrl, regfilemux_lhu);
          default:  ctrl = with_load_regfile(ctrl, regfilemux_lw);
        endcase
        ctrl    = with_load_pc(ctrl, pcmux_pc_plus4);
        state_d = FETCH1;
      end

      ST1: begin
        ctrl.mem_write       = 1'b1;
        ctrl.mem_byte_enable = store_byte_enable(funct3, mem_align);
        if (mem_resp) state_d = ST2;
      end

      ST2: begin
        ctrl    = with_load_pc(ctrl, pcmux_pc_plus4);
        state_d = FETCH1;
      end

      default: state_d = FETCH1;
    endcase

    // Reset forces quiet outputs immediately so an in-flight request drops
    // in the same cycle.
    if (rst) begin
      ctrl    = set_defaults(funct3);
      state_d = FETCH1;
    end
  end

  assign load_pc         = ctrl.load_pc;
  assign load_ir         = ctrl.load_ir;
  assign load_regfile    = ctrl.load_regfile;
  assign load_mar        = ctrl.load_mar;
  assign load_mdr        = ctrl.load_mdr;
  assign load_data_out   = ctrl.load_data_out;
  assign pcmux_sel       = ctrl.pcmux_sel;
  assign alumux1_sel     = ctrl.alumux1_sel;
  assign alumux2_sel     = ctrl.alumux2_sel;
  assign regfilemux_sel  = ctrl.regfilemux_sel;
  assign marmux_sel      = ctrl.marmux_sel;
  assign cmpmux_sel      = ctrl.cmpmux_sel;
  assign aluop           = ctrl.aluop;
  assign cmpop           = ctrl.cmpop;
  assign mem_byte_enable = ctrl.mem_byte_enable;
  assign mem_read        = ctrl.mem_read;
  assign mem_write       = ctrl.mem_write;

endmodule

// File: tb/tb_control.sv
// Directed bench for the control FSM: reset behaviour, fetch handshake,
// dispatch of each instruction class and store byte lanes.
module tb_control;
  import control_pkg::*;

  logic            clk;
  logic            rst;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            br_en;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [1:0]      mem_align;
  logic            mem_resp;
  logic            load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
  pcmux_sel_t      pcmux_sel;
  alumux1_sel_t    alumux1_sel;
  alumux2_sel_t    alumux2_sel;
  regfilemux_sel_t regfilemux_sel;
  marmux_sel_t     marmux_sel;
  cmpmux_sel_t     cmpmux_sel;
  alu_ops          aluop;
  branch_funct3_t  cmpop;
  logic [3:0]      mem_byte_enable;
  logic            mem_read, mem_write;

  int n_checks = 0;
  int n_fail   = 0;

  // {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out, mem_read, mem_write}
  logic [7:0] loads_v;
  assign loads_v = {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out, mem_read, mem_write};

  control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .br_en(br_en), .rs1(rs1), .rs2(rs2), .mem_align(mem_align), .mem_resp(mem_resp),
    .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
    .load_mar(load_mar), .load_mdr(load_mdr), .load_data_out(load_data_out),
    .pcmux_sel(pcmux_sel), .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
    .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel), .cmpmux_sel(cmpmux_sel),
    .aluop(aluop), .cmpop(cmpop), .mem_byte_enable(mem_byte_enable),
    .mem_read(mem_read), .mem_write(mem_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("[TB] check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic be, input logic [1:0] align);
    opcode    = op;
    funct3    = f3;
    funct7    = f7;
    br_en     = be;
    mem_align = align;
  endtask

  // Moves to the next cycle and lets combinational outputs settle.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Memory wait state lasting n cycles with mem_resp on the last; counts the
  // cycles whose load vector matched.
  task automatic memPhase(input string tag, input int n, input logic [7:0] exp_loads);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      mem_resp = (i == n - 1);
      #1;
      if (loads_v === exp_loads) cnt++;
      step();
    end
    mem_resp = 1'b0;
    checkOutput(tag, 32'(cnt), 32'(n));
  endtask

  // From FETCH1 through to DECODE.
  task automatic doFetch(input string tag, input int wait_cycles);
    int ir_cnt;
    #1;
    checkOutput({tag, ":fetch1"}, 32'(loads_v), 32'h10);
    step();
    memPhase({tag, ":fetch2_wait"}, wait_cycles, 8'b0000_1010);
    checkOutput({tag, ":fetch3"}, 32'(loads_v), 32'h40);
    ir_cnt = int'(load_ir);
    step();
    ir_cnt += int'(load_ir);
    checkOutput({tag, ":load_ir_once"}, 32'(ir_cnt), 32'd1);
  endtask

  initial begin
    rs1 = 5'd1; rs2 = 5'd1; mem_resp = 1'b0;
    rst = 1'b1;
    applyStimulus(7'b0110011, 3'b110, 7'h00, 1'b0, 2'b00);

    // Reset: quiet defaults
    step();
    checkOutput("rst_loads", 32'(loads_v), 32'h00);
    checkOutput("rst_pcmux", 32'(pcmux_sel), 32'(pcmux_pc_plus4));
    checkOutput("rst_be", 32'(mem_byte_enable), 32'hF);
    checkOutput("rst_aluop", 32'(aluop), 32'd6);
    checkOutput("rst_cmpop", 32'(cmpop), 32'd6);
    step();
    rst = 1'b0;
    #1;
    checkOutput("post_rst_fetch1", 32'(loads_v), 32'h10);
    checkOutput("fetch1_marmux", 32'(marmux_sel), 32'(marmux_pc_out));

    // Reset in the middle of FETCH2
    step();
    checkOutput("fetch2_req", 32'(loads_v), 32'h0A);
    rst = 1'b1;
    #1;
    checkOutput("rst_drop_same_cycle", 32'(loads_v), 32'h00);
    step();
    checkOutput("rst_hold_1", 32'(loads_v), 32'h00);
    step();
    rst = 1'b0;

    // Late mem_resp in FETCH1 is ignored; fetch with 5-cycle memory
    mem_resp = 1'b1;
    applyStimulus(op_imm, 3'b000, 7'h00, 1'b0, 2'b00);
    doFetch("addi", 5);
    checkOutput("addi_decode", 32'(loads_v), 32'h00);
    step();
    mem_resp = 1'b1;
    #1;
    checkOutput("addi_loads", 32'(loads_v), 32'hA0);
    checkOutput("addi_aluop", 32'(aluop), 32'(alu_add));
    checkOutput("addi_rfmux", 32'(regfilemux_sel), 32'(regfilemux_alu_out));
    checkOutput("addi_pcmux", 32'(pcmux_sel), 32'(pcmux_pc_plus4));
    step();

    // sub x2,x1,x1
    applyStimulus(op_reg, 3'b000, 7'b0100000, 1'b0, 2'b00);
    doFetch("sub", 1);
    step();
    checkOutput("sub_loads", 32'(loads_v), 32'hA0);
    checkOutput("sub_aluop", 32'(aluop), 32'(alu_sub));
    checkOutput("sub_alumux2", 32'(alumux2_sel), 32'(alumux2_rs2_out));
    step();

    // slti x3,x1,7
    applyStimulus(op_imm, 3'b010, 7'h00, 1'b1, 2'b00);
    doFetch("slti", 2);
    step();
    checkOutput("slti_cmpop", 32'(cmpop), 32'(blt));
    checkOutput("slti_cmpmux", 32'(cmpmux_sel), 32'(cmpmux_i_imm));
    checkOutput("slti_rfmux", 32'(regfilemux_sel), 32'(regfilemux_br_en));
    step();

    // srai
    applyStimulus(op_imm, 3'b101, 7'b0100000, 1'b0, 2'b00);
    doFetch("srai", 1);
    step();
    checkOutput("srai_aluop", 32'(aluop), 32'(alu_sra));
    step();

    // sltu (register form)
    applyStimulus(op_reg, 3'b011, 7'h00, 1'b0, 2'b00);
    doFetch("sltu", 1);
    step();
    checkOutput("sltu_cmpop", 32'(cmpop), 32'(bltu));
    checkOutput("sltu_cmpmux", 32'(cmpmux_sel), 32'(cmpmux_rs2_out));
    checkOutput("sltu_rfmux", 32'(regfilemux_sel), 32'(regfilemux_br_en));
    step();

    // beq x0,x0,+8 taken
    applyStimulus(op_br, 3'b000, 7'h00, 1'b1, 2'b00);
    doFetch("beq", 1);
    step();
    checkOutput("beq_loads", 32'(loads_v), 32'h80);
    checkOutput("beq_pcmux", 32'(pcmux_sel), 32'(pcmux_alu_out));
    checkOutput("beq_alumux1", 32'(alumux1_sel), 32'(alumux1_pc_out));
    checkOutput("beq_alumux2", 32'(alumux2_sel), 32'(alumux2_b_imm));
    checkOutput("beq_cmpop", 32'(cmpop), 32'(beq));
    step();

    // bne x0,x0,+8 not taken
    applyStimulus(op_br, 3'b001, 7'h00, 1'b0, 2'b00);
    doFetch("bne", 1);
    step();
    checkOutput("bne_pcmux", 32'(pcmux_sel), 32'(pcmux_pc_plus4));
    checkOutput("bne_loads", 32'(loads_v), 32'h80);
    step();

    // jalr x1,4(x1)
    applyStimulus(op_jalr, 3'b000, 7'h00, 1'b0, 2'b00);
    doFetch("jalr", 1);
    step();
    checkOutput("jalr_loads", 32'(loads_v), 32'hA0);
    checkOutput("jalr_pcmux", 32'(pcmux_sel), 32'(pcmux_alu_mod2));
    checkOutput("jalr_rfmux", 32'(regfilemux_sel), 32'(regfilemux_pc_plus4));
    checkOutput("jalr_alumux1", 32'(alumux1_sel), 32'(alumux1_rs1_out));
    checkOutput("jalr_alumux2", 32'(alumux2_sel), 32'(alumux2_i_imm));
    step();

    // jal
    applyStimulus(op_jal, 3'b000, 7'h00, 1'b0, 2'b00);
    doFetch("jal", 1);
    step();
    checkOutput("jal_alumux1", 32'(alumux1_sel), 32'(alumux1_pc_out));
    checkOutput("jal_alumux2", 32'(alumux2_sel), 32'(alumux2_j_imm));
    checkOutput("jal_pcmux", 32'(pcmux_sel), 32'(pcmux_alu_mod2));
    step();

    // lui
    applyStimulus(op_lui, 3'b000, 7'h00, 1'b0, 2'b00);
    doFetch("lui", 1);
    step();
    checkOutput("lui_loads", 32'(loads_v), 32'hA0);
    checkOutput("lui_rfmux", 32'(regfilemux_sel), 32'(regfilemux_u_imm));
    step();

    // auipc with immediate bits in the funct3 field
    applyStimulus(op_auipc, 3'b111, 7'h00, 1'b0, 2'b00);
    doFetch("auipc", 1);
    step();
    checkOutput("auipc_aluop", 32'(aluop), 32'(alu_add));
    checkOutput("auipc_alumux1", 32'(alumux1_sel), 32'(alumux1_pc_out));
    checkOutput("auipc_alumux2", 32'(alumux2_sel), 32'(alumux2_u_imm));
    step();

    // sb at address ...3
    applyStimulus(op_store, 3'b000, 7'h00, 1'b0, 2'b11);
    doFetch("sb", 1);
    step();
    checkOutput("sb_calc_loads", 32'(loads_v), 32'h14);
    checkOutput("sb_calc_be", 32'(mem_byte_enable), 32'h8);
    checkOutput("sb_calc_marmux", 32'(marmux_sel), 32'(marmux_alu_out));
    checkOutput("sb_calc_alumux2", 32'(alumux2_sel), 32'(alumux2_s_imm));
    step();
    #1;
    checkOutput("sb_st1_be", 32'(mem_byte_enable), 32'h8);
    memPhase("sb_st1_wait", 2, 8'b0000_0001);
    checkOutput("sb_st2_loads", 32'(loads_v), 32'h80);
    step();

    // sh at address ...2
    applyStimulus(op_store, 3'b001, 7'h00, 1'b0, 2'b10);
    doFetch("sh", 1);
    step();
    checkOutput("sh_calc_be", 32'(mem_byte_enable), 32'hC);
    step();
    #1;
    checkOutput("sh_st1_be", 32'(mem_byte_enable), 32'hC);
    memPhase("sh_st1_wait", 1, 8'b0000_0001);
    step();

    // lb at align 2
    applyStimulus(op_load, 3'b000, 7'h00, 1'b0, 2'b10);
    doFetch("lb", 1);
    step();
    checkOutput("lb_calc_loads", 32'(loads_v), 32'h10);
    checkOutput("lb_calc_alumux2", 32'(alumux2_sel), 32'(alumux2_i_imm));
    checkOutput("lb_calc_marmux", 32'(marmux_sel), 32'(marmux_alu_out));
    step();
    memPhase("lb_ld1_wait", 3, 8'b0000_1010);
    checkOutput("lb_ld2_loads", 32'(loads_v), 32'hA0);
    checkOutput("lb_ld2_rfmux", 32'(regfilemux_sel), 32'(regfilemux_lb));
    step();

    // Reset during a store wait drops mem_write immediately
    applyStimulus(op_store, 3'b010, 7'h00, 1'b0, 2'b00);
    doFetch("sw", 1);
    step();
    checkOutput("sw_calc_be", 32'(mem_byte_enable), 32'hF);
    step();
    #1;
    checkOutput("sw_st1_loads", 32'(loads_v), 32'h01);
    rst = 1'b1;
    #1;
    checkOutput("sw_rst_drop", 32'(loads_v), 32'h00);
    step();
    rst = 1'b0;

    // Illegal opcode: PC steps by 4 only
    applyStimulus(7'b0000000, 3'b000, 7'h00, 1'b0, 2'b00);
    doFetch("illegal", 1);
    checkOutput("illegal_decode_loads", 32'(loads_v), 32'h80);
    checkOutput("illegal_pcmux", 32'(pcmux_sel), 32'(pcmux_pc_plus4));
    step();
    checkOutput("illegal_next_fetch1", 32'(loads_v), 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
